// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions used by the writeback stage and the load
// alignment logic.
//   - funct3 encodings for the load instructions
//   - writeback FSM state type
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Load data alignment and extension. Purely combinational so the
// forwarding path can reuse it.
// Ports:
//   funct3  in  3  load type
//   addr    in  2  low byte-address bits of the load
//   rdata   in  32 word-aligned memory read data
//   result  out 32 aligned, sign/zero-extended load value
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*addr +: 8];
  // addr[0] does not participate: misaligned halfwords read the aligned half.
  assign half_sel = rdata[16*addr[1] +: 16];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback.sv
// rv32i writeback stage: drives the register-file write port, waits on the
// data-memory response for loads and stalls upstream meanwhile.
// Optional feature macro: WB_LOAD_TIMEOUT_EN (adds the load timeout counter
// and the load_timeout port).
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   WB_IDLE      | accepting instructions; non-loads write next cycle
//   WB_WAIT_LOAD | load outstanding; stall high until ack (or timeout)
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   valid_in, is_load     instruction present / is a load
//   wr_rd_in, rd_addr_in  instruction writes rd / destination register
//   funct3_in, result_in  load type / ALU result or load byte address
//   dmem_ack, dmem_rdata  data-memory read response
//   stall                 upstream must hold
//   rd_addr, rd, wr       register-file write port (wr is a 1-cycle pulse)
//   load_timeout          abort pulse (WB_LOAD_TIMEOUT_EN only)
module rv32i_writeback
  import rv32i_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        wr_rd_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] result_in,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd,
  output logic        wr
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  output logic        load_timeout
`endif
);

  if (LOAD_TIMEOUT < 1) begin : g_bad_timeout
    $error("LOAD_TIMEOUT must be at least 1");
  end

  wb_state_t   state, state_nxt;
  logic        wr_nxt;
  logic [31:0] rd_nxt;
  logic [4:0]  rd_addr_nxt;
  logic        ld_take;

  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_addr;
  logic        ld_wr;
  logic [31:0] align_data;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(LOAD_TIMEOUT + 1) > 8) ? $clog2(LOAD_TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             to_nxt;
`endif

  rv32i_load_align u_align (
    .funct3 (ld_f3),
    .addr   (ld_addr),
    .rdata  (dmem_rdata),
    .result (align_data)
  );

  // stall stays high through the ack cycle so a load write can never
  // coincide with the following instruction's write.
  assign stall = (state == WB_WAIT_LOAD);

  always_comb begin
    state_nxt   = state;
    wr_nxt      = 1'b0;
    rd_nxt      = rd;
    rd_addr_nxt = rd_addr;
    ld_take     = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_nxt     = cnt;
    to_nxt      = 1'b0;
`endif
    case (state)
      WB_IDLE: begin
        if (valid_in) begin
          if (is_load) begin
            ld_take   = 1'b1;
            state_nxt = WB_WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
          end else begin
            rd_nxt      = result_in;
            rd_addr_nxt = rd_addr_in;
            wr_nxt      = wr_rd_in && (rd_addr_in != 5'd0);
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_ack) begin
          rd_nxt      = align_data;
          rd_addr_nxt = ld_rd;
          wr_nxt      = ld_wr;
          state_nxt   = WB_IDLE;
        end
`ifdef WB_LOAD_TIMEOUT_EN
        // cnt counts completed ack-less wait cycles; the current one is the
        // LOAD_TIMEOUT-th when cnt == LOAD_TIMEOUT-1.
        else if (cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
          state_nxt = WB_IDLE;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WB_IDLE;
      wr      <= 1'b0;
      rd      <= 32'h0;
      rd_addr <= 5'd0;
    end else begin
      state   <= state_nxt;
      wr      <= wr_nxt;
      rd      <= rd_nxt;
      rd_addr <= rd_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd   <= 5'd0;
      ld_f3   <= 3'd0;
      ld_addr <= 2'd0;
      ld_wr   <= 1'b0;
    end else if (ld_take) begin
      ld_rd   <= rd_addr_in;
      ld_f3   <= funct3_in;
      ld_addr <= result_in[1:0];
      ld_wr   <= wr_rd_in && (rd_addr_in != 5'd0);
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      load_timeout <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      load_timeout <= to_nxt;
    end
  end
`endif

endmodule
